// File: rtl/renas_ahb_timer_pkg.sv
// Shared AHB / user definitions for the renas AHB timer.
// Holds the AHB encodings (htrans, hsize, hresp), the register map of the
// timer (word index and byte offset), CTRL bit positions, the response FSM
// state type and the master/slave bus bundles.
package renas_ahb_timer_pkg;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Register word indices; the byte offsets below are derived from them so
  // the two can never drift apart.
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_PRESC  = 3'd1;
  localparam logic [2:0] IDX_CMP    = 3'd2;
  localparam logic [2:0] IDX_COUNT  = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  localparam logic [31:0] REG_CTRL   = {27'd0, IDX_CTRL,   2'b00};
  localparam logic [31:0] REG_PRESC  = {27'd0, IDX_PRESC,  2'b00};
  localparam logic [31:0] REG_CMP    = {27'd0, IDX_CMP,    2'b00};
  localparam logic [31:0] REG_COUNT  = {27'd0, IDX_COUNT,  2'b00};
  localparam logic [31:0] REG_STATUS = {27'd0, IDX_STATUS, 2'b00};

  // CTRL / STATUS bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int STATUS_MATCH     = 0;

  // Response FSM: ERR1 is the wait-state half of the ERROR response
  typedef enum logic [1:0] {
    RSP_OKAY = 2'd0,
    RSP_ERR1 = 2'd1,
    RSP_ERR2 = 2'd2
  } rsp_state_e;

  // Master -> slave bundle
  typedef struct packed {
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
  } mas_send_type;

  // Slave -> master bundle
  typedef struct packed {
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
  } slv_send_type;

endpackage

// File: rtl/renas_ahb_timer.sv
// AHB slave timer: prescaled 32-bit up-counter with compare match and a
// level interrupt.
// Ports:
//   hclk, hreset        - AHB clock, asynchronous active-high reset
//   hsel/haddr/htrans/hwrite/hsize/hwdata/hready - AHB slave inputs
//   hrdata/hreadyout/hresp - AHB slave response (zero-wait OKAY,
//                            two-cycle ERROR for illegal accesses)
//   timer_irq           - registered MATCH & IRQ_EN
// Registers: 0x00 CTRL{AUTO_RELOAD,IRQ_EN,EN}, 0x04 PRESC, 0x08 CMP,
//            0x0C COUNT, 0x10 STATUS{MATCH, W1C}.
module renas_ahb_timer
  import renas_ahb_timer_pkg::*;
#(
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] BASE_MASK = 32'h0000_00FF
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic        timer_irq
);

  mas_send_type mst;
  slv_send_type slv;

  assign mst.hsel   = hsel;
  assign mst.haddr  = haddr;
  assign mst.htrans = htrans;
  assign mst.hwrite = hwrite;
  assign mst.hsize  = hsize;
  assign mst.hwdata = hwdata;
  assign mst.hready = hready;

  assign hrdata    = slv.hrdata;
  assign hreadyout = slv.hreadyout;
  assign hresp     = slv.hresp;

  // ---------------- address phase decode ----------------
  logic [31:0] ap_off;
  logic        ap_valid, ap_legal;

  assign ap_off   = mst.haddr & BASE_MASK;
  assign ap_valid = mst.hsel & mst.hready &
                    ((mst.htrans == HTRANS_NONSEQ) || (mst.htrans == HTRANS_SEQ));
  assign ap_legal = (ap_off <= REG_STATUS) && (ap_off[1:0] == 2'b00) &&
                    (mst.hsize == HSIZE_WORD);

  // Registered address phase; only legal transfers open a data phase, so an
  // illegal one can never touch a register.
  logic       dp_act, dp_wr;
  logic [2:0] dp_idx;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_act <= 1'b0;
      dp_wr  <= 1'b0;
      dp_idx <= '0;
    end else if (mst.hready) begin
      dp_act <= ap_valid & ap_legal;
      dp_wr  <= mst.hwrite;
      dp_idx <= ap_off[4:2];
    end
  end

  // ---------------- response FSM ----------------
  rsp_state_e st, st_nxt;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) st <= RSP_OKAY;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      RSP_OKAY: if (ap_valid && !ap_legal) st_nxt = RSP_ERR1;
      RSP_ERR1: st_nxt = RSP_ERR2;
      RSP_ERR2: st_nxt = (ap_valid && !ap_legal) ? RSP_ERR1 : RSP_OKAY;
      default:  st_nxt = RSP_OKAY;
    endcase
  end

  logic [31:0] rd_data;

  always_comb begin
    slv           = '0;
    slv.hreadyout = (st != RSP_ERR1);
    slv.hresp     = (st == RSP_OKAY) ? HRESP_OKAY : HRESP_ERROR;
    slv.hrdata    = rd_data;
  end

  // ---------------- registers ----------------
  logic               ctrl_en, ctrl_irq_en, ctrl_auto;
  logic [PRESC_W-1:0] presc, presc_cnt;
  logic [31:0]        cmp, count;
  logic               match, irq_q;

  logic wr_en, wr_ctrl, wr_presc, wr_cmp, wr_count, wr_clr;
  logic tick, hit;

  // The data phase ends on the edge where hready is high
  assign wr_en    = dp_act & dp_wr & mst.hready;
  assign wr_ctrl  = wr_en && (dp_idx == IDX_CTRL);
  assign wr_presc = wr_en && (dp_idx == IDX_PRESC);
  assign wr_cmp   = wr_en && (dp_idx == IDX_CMP);
  assign wr_count = wr_en && (dp_idx == IDX_COUNT);
  assign wr_clr   = wr_en && (dp_idx == IDX_STATUS) && mst.hwdata[STATUS_MATCH];

  assign tick = ctrl_en && (presc_cnt == presc);
  assign hit  = tick && (count == cmp);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_auto   <= 1'b0;
      presc       <= '0;
      cmp         <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= mst.hwdata[CTRL_EN];
        ctrl_irq_en <= mst.hwdata[CTRL_IRQ_EN];
        ctrl_auto   <= mst.hwdata[CTRL_AUTO_RELOAD];
      end
      if (wr_presc) presc <= mst.hwdata[PRESC_W-1:0];
      if (wr_cmp)   cmp   <= mst.hwdata;
    end
  end

  // Prescaler: held at 0 while disabled or just after PRESC is rewritten
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                        presc_cnt <= '0;
    else if (wr_presc || !ctrl_en || tick) presc_cnt <= '0;
    else                               presc_cnt <= presc_cnt + PRESC_W'(1);
  end

  // Software write to COUNT takes priority over a simultaneous tick
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)        count <= '0;
    else if (wr_count) count <= mst.hwdata;
    else if (tick)     count <= (hit && ctrl_auto) ? 32'd0 : count + 32'd1;
  end

  // A new match beats a simultaneous W1C so the event is never lost
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      match <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (hit)         match <= 1'b1;
      else if (wr_clr) match <= 1'b0;
      irq_q <= match & ctrl_irq_en;
    end
  end

  assign timer_irq = irq_q;

  // Read mux: zero outside a read data phase
  always_comb begin
    rd_data = '0;
    if (dp_act && !dp_wr) begin
      case (dp_idx)
        IDX_CTRL: begin
          rd_data[CTRL_EN]          = ctrl_en;
          rd_data[CTRL_IRQ_EN]      = ctrl_irq_en;
          rd_data[CTRL_AUTO_RELOAD] = ctrl_auto;
        end
        IDX_PRESC:  rd_data[PRESC_W-1:0] = presc;
        IDX_CMP:    rd_data = cmp;
        IDX_COUNT:  rd_data = count;
        IDX_STATUS: rd_data[STATUS_MATCH] = match;
        default:    rd_data = '0;
      endcase
    end
  end

endmodule

// File: doc/renas_ahb_timer.md
RENAS_AHB_TIMER -- requirements
Module: renas_ahb_timer

Interface
REQ-001 The block SHALL have parameter PRESC_W, default 16, giving the prescaler register width in bits.
REQ-002 The block SHALL have parameter BASE_MASK, default 32'h0000_00FF, giving the haddr bits decoded as register offset.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: hclk in 1, the rising-edge AHB clock.
REQ-004 hreset in 1: asynchronous, active-high reset.
REQ-005 hsel in 1: slave select from the AHB decoder (peripheral slot).
REQ-006 haddr in 32: transfer address; only haddr & BASE_MASK is used.
REQ-007 htrans in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 hwrite in 1: 1 = write.
REQ-009 hsize in 3: transfer size; only 3'b010 (word) is legal.
REQ-010 hwdata in 32: write data, valid in the data phase.
REQ-011 hready in 1: bus-wide ready; an address phase is sampled only when it is 1.
REQ-012 hrdata out 32: read data.
REQ-013 hreadyout out 1: slave ready.
REQ-014 hresp out 1: 0 = OKAY, 1 = ERROR.
REQ-015 timer_irq out 1: level interrupt to the CPU interrupt handler.

Function
REQ-016 A valid transfer SHALL be hsel & hready & htrans[1] in the address phase; haddr, hwrite and hsize are registered at that edge for the data phase.
REQ-017 The register map (offset, access, field) SHALL be:
- 0x00 CTRL, RW: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD.
- 0x04 PRESC, RW: [PRESC_W-1:0].
- 0x08 CMP, RW: 32 bits.
- 0x0C COUNT, RW: 32 bits.
- 0x10 STATUS: bit0 MATCH, write-1-to-clear.
Unused bits SHALL read 0.
REQ-018 An OKAY transfer SHALL take zero wait states: hreadyout=1 and hresp=0 in its data phase.
REQ-019 Writes SHALL commit at the end of the data phase using hwdata.
REQ-020 hrdata SHALL be valid throughout a read data phase and SHALL be 0 at all other times.
REQ-021 An address phase SHALL be illegal if the offset is >0x10, the offset is not word-aligned, or hsize!=3'b010.
REQ-022 An illegal address phase SHALL get the two-cycle ERROR response: cycle 1 hreadyout=0 and hresp=1; cycle 2 hreadyout=1 and hresp=1. No register SHALL change.
REQ-023 Response FSM states and transitions:
- OKAY -> ERR1 on an illegal valid address phase.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> OKAY, or -> ERR1 if a new illegal transfer is sampled in ERR2.
REQ-024 IDLE, BUSY, or hsel=0 SHALL produce OKAY with zero wait states and no side effect.
REQ-025 The prescaler counter SHALL run only while EN=1. It counts 0..PRESC; at PRESC it returns to 0 and asserts an internal one-cycle tick. PRESC=0 SHALL give a tick every cycle.
REQ-026 On each tick, COUNT SHALL increment modulo 2^32.
REQ-027 If COUNT==CMP on a tick, MATCH SHALL be set. COUNT SHALL then go to 0 if AUTO_RELOAD=1, otherwise increment (0xFFFF_FFFF wraps to 0).
REQ-028 Clearing EN SHALL freeze COUNT and reset the prescaler counter to 0.
REQ-029 A software write to COUNT coinciding with a tick SHALL win.
REQ-030 A software write to PRESC SHALL reset the prescaler counter to 0.
REQ-031 A MATCH set coinciding with a W1C clear SHALL leave MATCH=1.
REQ-032 timer_irq SHALL be a registered copy of MATCH & IRQ_EN, asserted one cycle after MATCH sets.

Reset
REQ-033 While hreset=1, all registers, prescaler counter, FSM (OKAY) and registered address phase SHALL clear, with outputs hrdata=0, hreadyout=1, hresp=0, timer_irq=0.
REQ-034 Reset asserted mid-transfer or mid-ERROR SHALL abort it immediately; the first post-reset address phase SHALL be treated as new.

Structure
REQ-035 Register offsets, CTRL bit positions, and the htrans/hsize/hresp encodings SHALL live in the shared AHB/user-define package with mas_send_type and slv_send_type.
REQ-036 The block SHALL be one module containing no sub-modules; the prescaler/counter SHALL be written inline.

Verification
REQ-037 Write CTRL=0x7, PRESC=1, CMP=3 -> MATCH set on COUNT 3 (8th cycle after EN); COUNT returns to 0; timer_irq high one cycle later.
REQ-038 Read 0x14 -> hreadyout 0 then 1, hresp 1 for both cycles; CTRL unchanged. Repeat with hsize=3'b000 at 0x00 -> same ERROR response.
REQ-039 AUTO_RELOAD=0, COUNT=0xFFFF_FFFF, PRESC=0, EN=1 -> COUNT reads 0x0000_0000 next tick, then 0x0000_0001.
REQ-040 Write STATUS=0x1 in the same cycle a match occurs -> MATCH reads 1; the next W1C with no match -> MATCH 0 and timer_irq 0 one cycle later.
REQ-041 Back-to-back write CMP=0x10 then read CMP (pipelined) -> read returns 0x0000_0010 with zero wait states.
REQ-042 Assert hreset during ERR1 -> hreadyout=1, hresp=0, all registers 0 immediately.
